// File: rtl/bt_pulse_pkg.sv
// rtl/bt_pulse_pkg.sv - shared state type and default sizing for the beacon burst framer
package bt_pulse_pkg;

   typedef enum logic [1:0] {
      IDLE     = 2'd0,
      IN_BURST = 2'd1,
      REPORT   = 2'd2
   } burst_state_t;

   localparam int BT_CNT_W      = 8;
   localparam int BT_PER_W      = 12;
   localparam int BT_GAP_CYCLES = 2048;

endpackage

// File: rtl/pulse_sync_edge.sv
// rtl/pulse_sync_edge.sv - two-flop synchronizer with a one-cycle rising-edge strobe
module pulse_sync_edge (
   input  logic clk,
   input  logic rst_n,
   input  logic d,
   output logic rise
);

   // [0],[1] form the synchronizer; [2] holds the previous synchronized level
   logic [2:0] sync_q;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sync_q <= 3'b000;
      end else begin
         sync_q <= {sync_q[1:0], d};
      end
   end

   assign rise = sync_q[1] & ~sync_q[2];

endmodule

// File: rtl/bt_burst_framer.sv
// rtl/bt_burst_framer.sv - counts pulses in a beacon burst, measures their period, reports on valid/ready
module bt_burst_framer
   import bt_pulse_pkg::*;
#(
   parameter int CNT_W      = BT_CNT_W,
   parameter int PER_W      = BT_PER_W,
   parameter int GAP_CYCLES = BT_GAP_CYCLES
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             pulse_in,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [CNT_W-1:0] out_count,
   output logic [PER_W-1:0] out_period,
   output logic             out_sat,
   output logic             overrun,
   output logic             busy
);

   localparam int GAP_W = $clog2(GAP_CYCLES);
   localparam logic [CNT_W-1:0] CNT_MAX  = '1;
   localparam logic [PER_W-1:0] PER_MAX  = '1;
   localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'(GAP_CYCLES - 1);

   burst_state_t     state_q;
   logic [CNT_W-1:0] count_q;
   logic [PER_W-1:0] period_q;
   logic [GAP_W-1:0] gap_q;
   logic             sat_q;
   logic             overrun_q;
   logic             out_valid_q;
   logic             busy_q;

   logic             rise_s;
   logic [CNT_W-1:0] count_d;
   logic [PER_W-1:0] period_d;
   logic [31:0]      gap_inc;
   logic             cnt_hit;
   logic             per_hit;

   pulse_sync_edge u_sync (
      .clk   (clk),
      .rst_n (rst_n),
      .d     (pulse_in),
      .rise  (rise_s)
   );

   // Period is measured in a wide domain so it saturates independently of the gap width
   always_comb begin
      gap_inc  = 32'(gap_q) + 32'd1;
      per_hit  = (gap_inc >= 32'(PER_MAX));
      period_d = per_hit ? PER_MAX : PER_W'(gap_inc);
      count_d  = (count_q == CNT_MAX) ? CNT_MAX : count_q + CNT_W'(1);
      cnt_hit  = (count_d == CNT_MAX);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= IDLE;
         count_q     <= '0;
         period_q    <= '0;
         gap_q       <= '0;
         sat_q       <= 1'b0;
         overrun_q   <= 1'b0;
         out_valid_q <= 1'b0;
         busy_q      <= 1'b0;
      end else begin
         case (state_q)
            IDLE: begin
               if (rise_s) begin
                  state_q  <= IN_BURST;
                  count_q  <= CNT_W'(1);
                  period_q <= '0;
                  gap_q    <= '0;
                  sat_q    <= 1'b0;
                  busy_q   <= 1'b1;
               end
            end
            IN_BURST: begin
               // An edge on the expiry cycle keeps the burst open
               if (rise_s) begin
                  count_q  <= count_d;
                  period_q <= period_d;
                  sat_q    <= sat_q | cnt_hit | per_hit;
                  gap_q    <= '0;
               end else if (gap_q == GAP_LAST) begin
                  state_q     <= REPORT;
                  out_valid_q <= 1'b1;
               end else begin
                  gap_q <= gap_q + GAP_W'(1);
               end
            end
            REPORT: begin
               if (rise_s) begin
                  overrun_q <= 1'b1;
               end
               if (out_ready) begin
                  state_q     <= IDLE;
                  out_valid_q <= 1'b0;
                  busy_q      <= 1'b0;
               end
            end
            default: begin
               state_q     <= IDLE;
               out_valid_q <= 1'b0;
               busy_q      <= 1'b0;
            end
         endcase
      end
   end

   assign out_valid  = out_valid_q;
   assign out_count  = count_q;
   assign out_period = period_q;
   assign out_sat    = sat_q;
   assign overrun    = overrun_q;
   assign busy       = busy_q;

endmodule

// File: tb/tb_bt_burst_framer.sv
// tb/tb_bt_burst_framer.sv - scoreboard bench for bt_burst_framer with a burst-level reference model
module tb_bt_burst_framer;

   localparam int CW   = 4;
   localparam int PW   = 6;
   localparam int GAP  = 128;
   localparam int CMAX = (1 << CW) - 1;
   localparam int PMAX = (1 << PW) - 1;

   logic          clk = 1'b0;
   logic          rst_n = 1'b0;
   logic          pulse_in = 1'b0;
   logic          out_ready = 1'b0;
   logic          out_valid;
   logic [CW-1:0] out_count;
   logic [PW-1:0] out_period;
   logic          out_sat;
   logic          overrun;
   logic          busy;

   bt_burst_framer #(.CNT_W(CW), .PER_W(PW), .GAP_CYCLES(GAP)) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .pulse_in   (pulse_in),
      .out_valid  (out_valid),
      .out_ready  (out_ready),
      .out_count  (out_count),
      .out_period (out_period),
      .out_sat    (out_sat),
      .overrun    (overrun),
      .busy       (busy)
   );

   always #5 clk = ~clk;

   typedef struct {
      int cnt;
      int per;
      bit sat;
   } rep_t;

   rep_t exp_q[$];
   int   errors = 0;
   int   checks = 0;
   int   accepted = 0;
   bit   exp_overrun = 1'b0;
   bit   force_low = 1'b0;

   task automatic chk(input string name, input int act, input int req);
      checks++;
      if (act !== req) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d", name, act, req);
      end
   endtask

   task automatic tick(input int n);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   function automatic int rand_iv();
      int r;
      r = $urandom_range(0, 9);
      if (r < 7) return $urandom_range(2, 90);
      case ($urandom_range(0, 3))
         0: return PMAX - 1;
         1: return PMAX;
         2: return PMAX + 1;
         default: return GAP;
      endcase
   endfunction

   task automatic pulse(input int p);
      int h;
      h = $urandom_range(1, p - 1);
      pulse_in = 1'b1;
      tick(h);
      pulse_in = 1'b0;
      tick(p - h);
   endtask

   // Expected report follows directly from the burst's pulse count and its last interval
   task automatic burst(input int n, input int fixed, input bit push);
      rep_t e;
      int   p;
      e.cnt = (n > CMAX) ? CMAX : n;
      e.sat = (n >= CMAX);
      e.per = 0;
      for (int i = 0; i < n; i++) begin
         if (i < n - 1) begin
            p = (fixed > 0) ? fixed : rand_iv();
            e.per = (p >= PMAX) ? PMAX : p;
            if (p >= PMAX) e.sat = 1'b1;
         end else begin
            p = $urandom_range(2, 40);
         end
         pulse(p);
      end
      if (push) exp_q.push_back(e);
   endtask

   task automatic wait_acc(input int target);
      int k;
      k = 0;
      while (accepted < target && k < GAP * 40) begin
         tick(1);
         k++;
      end
      chk("accept_count", accepted, target);
   endtask

   initial begin
      forever begin
         @(posedge clk);
         #1;
         out_ready = force_low ? 1'b0 : ($urandom_range(0, 9) < 7);
      end
   end

   initial begin : monitor
      bit   in_rep;
      bit   busy_chk;
      int   s_cnt, s_per, s_sat;
      rep_t e;
      in_rep = 1'b0;
      busy_chk = 1'b0;
      forever begin
         @(negedge clk);
         if (!rst_n) begin
            in_rep = 1'b0;
            busy_chk = 1'b0;
         end else begin
            if (busy_chk) begin
               chk("busy_after_handshake", int'(busy), 0);
               chk("valid_after_handshake", int'(out_valid), 0);
               busy_chk = 1'b0;
            end
            if (in_rep && !out_valid) begin
               checks++;
               errors++;
               $display("FAIL valid_dropped: got out_valid=0 expected 1 until handshake");
               in_rep = 1'b0;
            end
            if (out_valid) begin
               if (!in_rep) begin
                  s_cnt = out_count;
                  s_per = out_period;
                  s_sat = out_sat;
                  in_rep = 1'b1;
               end
               if (out_ready) begin
                  chk("stable_count", int'(out_count), s_cnt);
                  chk("stable_period", int'(out_period), s_per);
                  chk("stable_sat", int'(out_sat), s_sat);
                  if (exp_q.size() == 0) begin
                     checks++;
                     errors++;
                     $display("FAIL unexpected_report: got count=%0d period=%0d expected no report",
                              out_count, out_period);
                  end else begin
                     e = exp_q.pop_front();
                     chk("report_count", int'(out_count), e.cnt);
                     chk("report_period", int'(out_period), e.per);
                     chk("report_sat", int'(out_sat), int'(e.sat));
                     chk("report_overrun", int'(overrun), int'(exp_overrun));
                  end
                  accepted++;
                  in_rep = 1'b0;
                  busy_chk = 1'b1;
               end
            end
         end
      end
   end

   initial begin
      #3_000_000;
      $display("FAIL watchdog: got no completion expected finish within time limit");
      $fatal(1, "watchdog");
   end

   initial begin : driver
      int n_acc;
      int k;
      rst_n = 1'b0;
      pulse_in = 1'b0;
      tick(2);
      @(negedge clk);
      chk("reset_valid", int'(out_valid), 0);
      chk("reset_count", int'(out_count), 0);
      chk("reset_period", int'(out_period), 0);
      chk("reset_sat", int'(out_sat), 0);
      chk("reset_overrun", int'(overrun), 0);
      chk("reset_busy", int'(busy), 0);
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      tick(3);
      n_acc = 0;

      burst(1, 0, 1);           n_acc++; wait_acc(n_acc); tick(5);
      burst(3, GAP, 1);         n_acc++; wait_acc(n_acc); tick(5);
      burst(20, 10, 1);         n_acc++; wait_acc(n_acc); tick(5);
      burst(2, 100, 1);         n_acc++; wait_acc(n_acc); tick(5);
      burst(4, PMAX - 1, 1);    n_acc++; wait_acc(n_acc); tick(5);

      for (int i = 0; i < 20; i++) begin
         burst($urandom_range(1, 18), 0, 1);
         n_acc++;
         wait_acc(n_acc);
         tick($urandom_range(1, 20));
      end

      force_low = 1'b1;
      tick(2);
      burst(3, 30, 1);
      k = 0;
      while (!out_valid && k < GAP * 4) begin
         tick(1);
         k++;
      end
      chk("report_pending", int'(out_valid), 1);
      burst(3, 20, 0);
      exp_overrun = 1'b1;
      tick(300);
      chk("overrun_sticky", int'(overrun), 1);
      chk("held_valid", int'(out_valid), 1);
      force_low = 1'b0;
      n_acc++;
      wait_acc(n_acc);
      tick(GAP * 3);
      chk("no_dropped_report", accepted, n_acc);

      burst(10, 30, 0);
      rst_n = 1'b0;
      exp_overrun = 1'b0;
      tick(1);
      chk("midrst_valid", int'(out_valid), 0);
      chk("midrst_count", int'(out_count), 0);
      chk("midrst_busy", int'(busy), 0);
      chk("midrst_overrun", int'(overrun), 0);
      tick(2);
      rst_n = 1'b1;
      tick(3);
      burst(4, 25, 1);
      n_acc++;
      wait_acc(n_acc);
      tick(GAP * 2);
      chk("final_accepts", accepted, n_acc);
      chk("queue_empty", exp_q.size(), 0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/bt_burst_framer.md
# bt_burst_framer

Downstream consumer of the Bluetooth beacon pulse generator. Samples the generator's burst pulse train `pulse_in`, counts rising edges within a burst, measures the edge-to-edge period and closes the burst after a programmable idle gap. Each closed burst is presented as a report on a valid/ready interface to the link-control logic.

## Interface
Parameters:
- `CNT_W`, 8: width of pulse count; count saturates at 2^CNT_W-1.
- `PER_W`, 12: width of period measurement in `clk` cycles; saturates at 2^PER_W-1.
- `GAP_CYCLES`, 2048: idle cycles with no rising edge that close a burst; must exceed the generator's 1317-cycle pulse period.

Ports:
- `clk`  in  1  single system clock; all logic on rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `pulse_in`  in  1  burst pulse train from the generator; treated as asynchronous.
- `out_valid`  out  1  report available.
- `out_ready`  in  1  consumer accepts report.
- `out_count`  out  CNT_W  rising edges in the burst.
- `out_period`  out  PER_W  cycles between the last two edges; 0 for a single-pulse burst.
- `out_sat`  out  1  count or period saturated during this burst.
- `overrun`  out  1  sticky: an edge arrived while a report was pending.
- `busy`  out  1  state is not IDLE.

## Operation
- Front end: 2-flop synchronizer, then rise detector producing a 1-cycle `edge` strobe.
- States: IDLE, IN_BURST, REPORT.
- IDLE: on `edge` go to IN_BURST, with count=1, gap=0, period=0, sat=0.
- IN_BURST:
  - On `edge`: count+1, saturating; period = gap+1, saturating; gap=0.
  - Otherwise gap+1.
  - When gap==GAP_CYCLES-1 and there is no `edge` that cycle, go to REPORT.
  - If `edge` and expiry coincide, the edge wins and the burst continues.
- REPORT:
  - `out_valid`=1; `out_count`, `out_period` and `out_sat` are held stable.
  - On `out_valid && out_ready`, go to IDLE next cycle.
  - An `edge` seen in REPORT is discarded and sets `overrun`.
  - An `edge` in the handshake cycle is also discarded.
- `overrun` is cleared only by reset.
- `out_sat` is set if count or period hits its saturation value in this burst; it clears on the next IDLE→IN_BURST transition.

## Timing
- Reset values:
  - All outputs 0; state IDLE.
  - Synchronizer flops, count, gap and period 0.
- Reset is asynchronous and may hit mid-burst or mid-report. The report is lost and no partial report is emitted.
- `pulse_in` high at reset release is a rising edge; it is detected 3 cycles after release.
- Latency:
  - Rising edge on `pulse_in` to `edge` strobe: 3 cycles.
  - Last `edge` to `out_valid`: GAP_CYCLES+1 cycles.
- Handshake:
  - `out_valid` never deasserts without a handshake.
  - Report data is stable while `out_valid`=1.
  - `out_ready` may be held high continuously.
  - Back-to-back bursts closer than report acceptance are dropped, not queued.
- Width rules: `gap` counter is clog2(GAP_CYCLES) bits wide. `period` saturates independently of `gap`.

## Structure
- Package `bt_pulse_pkg`:
  - state enum `burst_state_t` (IDLE, IN_BURST, REPORT);
  - default constants `BT_CNT_W`, `BT_PER_W`, `BT_GAP_CYCLES`.
- Sub-module `pulse_sync_edge`:
  - 2-flop synchronizer plus rise detector;
  - ports `clk`, `rst_n`, `d`, `rise`;
  - reused by other asynchronous inputs.
- Top `bt_burst_framer` contains the FSM, counters and report registers.

## Test plan
- Nominal beacon burst: 21 pulses, period 1317 cycles, high 330 cycles, `out_ready`=1 → one report 2049 cycles after last edge: count=21, period=1317, sat=0, overrun=0.
- Single pulse, then idle → report count=1, period=0; `busy` falls 1 cycle after handshake.
- `out_ready`=0 for 5000 cycles while a second burst of 3 pulses arrives → first report held unchanged, `overrun`=1, no second report after `out_ready` rises.
- Saturation with CNT_W=4: 20 pulses at period 100 → count=15, sat=1. With PER_W=6, 2 pulses at period 100 → period=63, sat=1.
- Edge on the exact expiry cycle (gap==GAP_CYCLES-1) → burst continues; count increments; period=GAP_CYCLES.
- Reset asserted mid-burst after 10 pulses, released with `pulse_in` low, then 4 pulses → single report count=4; all outputs 0 during reset.
